// File: rtl/cond_pkg.sv
// Shared constants for the conditional-execution stage: ARM condition codes,
// NZCV bit positions and the FlagW field layout.
package cond_pkg;

    // ARM condition field encodings (Instr[31:28])
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the NZCV nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // FlagW bit positions: bit FW_x enables the flag pair at bits [2*FW_x+1 : 2*FW_x]
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: ARM condition field vs. NZCV.
// The reserved code 1111 never executes and is flagged as undefined.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex,
    output logic       cond_undef
);

    logic n_flag;
    logic z_flag;
    logic c_flag;
    logic v_flag;

    assign n_flag = flags[FLAG_N];
    assign z_flag = flags[FLAG_Z];
    assign c_flag = flags[FLAG_C];
    assign v_flag = flags[FLAG_V];

    // Decode every condition code explicitly so no input pattern yields X
    always_comb begin
        cond_ex    = 1'b0;
        cond_undef = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z_flag;
            COND_NE: cond_ex = ~z_flag;
            COND_CS: cond_ex = c_flag;
            COND_CC: cond_ex = ~c_flag;
            COND_MI: cond_ex = n_flag;
            COND_PL: cond_ex = ~n_flag;
            COND_VS: cond_ex = v_flag;
            COND_VC: cond_ex = ~v_flag;
            COND_HI: cond_ex = c_flag & ~z_flag;
            COND_LS: cond_ex = ~c_flag | z_flag;
            COND_GE: cond_ex = (n_flag == v_flag);
            COND_LT: cond_ex = (n_flag != v_flag);
            COND_GT: cond_ex = ~z_flag & (n_flag == v_flag);
            COND_LE: cond_ex = z_flag | (n_flag != v_flag);
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_undef = 1'b1;
            default: begin
                cond_ex    = 1'b0;
                cond_undef = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage after the ALU: holds the NZCV register, tests
// the instruction's condition against it and gates the decoder write strobes.
module cond_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET = 4'b0000,
    parameter bit         NOWRITE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic       CondUndef,
    output logic [3:0] Flags
);

    logic [3:0] flags_reg;
    logic [3:0] flags_next;
    logic       cond_ex;
    logic       cond_undef;
    logic       nowrite_block;

    // Condition is tested against the stored flags, never the incoming ALU flags,
    // so an instruction sees the result of earlier instructions only.
    cond_check u_cond_check (
        .cond       (Cond),
        .flags      (flags_reg),
        .cond_ex    (cond_ex),
        .cond_undef (cond_undef)
    );

    // Each FlagW bit owns one flag pair: FW_CV -> bits [1:0], FW_NZ -> bits [3:2].
    // A pair loads only when enabled and the instruction actually executes.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_flag_half
            assign flags_next[2*gi +: 2] = (FlagW[gi] & cond_ex) ? ALUFlags[2*gi +: 2]
                                                                  : flags_reg[2*gi +: 2];
        end
    endgenerate

    // NZCV register: reset wins over stall, stall freezes all four bits
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_reg <= FLAG_RESET;
        end else if (!Stall) begin
            flags_reg <= flags_next;
        end
    end

    // Compare-class instructions produce flags only, never a register result
    assign nowrite_block = NoWrite & NOWRITE_EN;

    // Strobes are killed during reset; stall does not touch them (upstream owns that)
    assign PCSrc     = reset & PCS  & cond_ex;
    assign MemWrite  = reset & MemW & cond_ex;
    assign RegWrite  = reset & RegW & cond_ex & ~nowrite_block;
    assign CondEx    = cond_ex;
    assign CondUndef = cond_undef;
    assign Flags     = flags_reg;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: directed scenarios plus a randomized run
// checked against an abstract NZCV / condition model.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic       CondUndef;
    logic [3:0] Flags;

    int total = 0;
    int bad   = 0;

    logic [3:0] model_flags = 4'h0;

    cond_logic dut (
        .clk       (clk),
        .reset     (reset),
        .Cond      (Cond),
        .ALUFlags  (ALUFlags),
        .FlagW     (FlagW),
        .PCS       (PCS),
        .RegW      (RegW),
        .MemW      (MemW),
        .NoWrite   (NoWrite),
        .Stall     (Stall),
        .PCSrc     (PCSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .CondEx    (CondEx),
        .CondUndef (CondUndef),
        .Flags     (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the upper three bits pick a base test, the low bit inverts it.
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0:    r = z;
            3'd1:    r = cf;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = cf && !z;
            3'd5:    r = (n == v);
            3'd6:    r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic logic [3:0] model_next();
        logic [3:0] nxt;
        nxt = model_flags;
        if (!reset) begin
            nxt = 4'h0;
        end else if (!Stall && cond_pass(Cond, model_flags)) begin
            if (FlagW[1]) nxt[3:2] = ALUFlags[3:2];
            if (FlagW[0]) nxt[1:0] = ALUFlags[1:0];
        end
        return nxt;
    endfunction

    // Advance one clock and keep the model in step; leaves time at posedge+1
    task automatic tick();
        logic [3:0] nxt;
        nxt = model_next();
        @(posedge clk);
        #1;
        model_flags = nxt;
    endtask

    task automatic drive(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                         input logic [1:0] fw, input logic pcs, input logic regw,
                         input logic memw, input logic nowr, input logic stall);
        reset    = rst;
        Cond     = c;
        ALUFlags = alu;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = regw;
        MemW     = memw;
        NoWrite  = nowr;
        Stall    = stall;
        #1;
    endtask

    // Load a known NZCV value with an always-executing flag-setting op
    task automatic load_flags(input logic [3:0] val);
        drive(1'b1, 4'hE, val, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got=%b exp=0", PCSrc); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL reset_memwrite got=%b exp=0", MemWrite); end
        tick();
        total++; if (Flags !== 4'h0) begin bad++; $display("FAIL reset_flags got=%h exp=0", Flags); end
        total++; if (CondEx !== 1'b1) begin bad++; $display("FAIL reset_condex_al got=%b exp=1", CondEx); end
        $display("test_reset: flags=%h", Flags);
    endtask

    task automatic test_cmp_beq();
        // CMP: sets Z and C, writes no register
        drive(1'b1, 4'hE, 4'b0110, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL cmp_regwrite got=%b exp=0", RegWrite); end
        tick();
        total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b exp=0110", Flags); end
        // BEQ taken
        drive(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (PCSrc !== 1'b1) begin bad++; $display("FAIL beq_pcsrc got=%b exp=1", PCSrc); end
        // BNE not taken
        drive(1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL bne_pcsrc got=%b exp=0", PCSrc); end
        // Same op without NoWrite does write the register
        drive(1'b1, 4'hE, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL add_regwrite got=%b exp=1", RegWrite); end
        $display("test_cmp_beq: flags=%b", Flags);
    endtask

    task automatic test_partial();
        load_flags(4'b1010);
        total++; if (Flags !== 4'b1010) begin bad++; $display("FAIL partial_setup got=%b exp=1010", Flags); end
        drive(1'b1, 4'hE, 4'b0101, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL partial_nz got=%b exp=0110", Flags); end
        drive(1'b1, 4'hE, 4'b1001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (Flags !== 4'b0101) begin bad++; $display("FAIL partial_cv got=%b exp=0101", Flags); end
        $display("test_partial: flags=%b", Flags);
    endtask

    task automatic test_failed_cond();
        load_flags(4'h0);
        drive(1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL failcond_condex got=%b exp=0", CondEx); end
        total++; if (MemWrite !== 1'b0) begin bad++; $display("FAIL failcond_memwrite got=%b exp=0", MemWrite); end
        tick();
        total++; if (Flags !== 4'h0) begin bad++; $display("FAIL failcond_flags got=%h exp=0", Flags); end
        $display("test_failed_cond: flags=%h", Flags);
    endtask

    task automatic test_signed_reserved();
        logic [3:0] codes [4];
        logic       exps  [4];
        codes[0] = 4'hB; exps[0] = 1'b1;  // LT
        codes[1] = 4'hA; exps[1] = 1'b0;  // GE
        codes[2] = 4'hC; exps[2] = 1'b0;  // GT
        codes[3] = 4'hD; exps[3] = 1'b1;  // LE
        load_flags(4'b1000);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, codes[k], 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            total++;
            if (CondEx !== exps[k]) begin
                bad++; $display("FAIL signed_cond cond=%h got=%b exp=%b", codes[k], CondEx, exps[k]);
            end
            total++;
            if (CondUndef !== 1'b0) begin
                bad++; $display("FAIL signed_undef cond=%h got=%b exp=0", codes[k], CondUndef);
            end
        end
        drive(1'b1, 4'hF, 4'h0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        total++; if (CondEx !== 1'b0) begin bad++; $display("FAIL nv_condex got=%b exp=0", CondEx); end
        total++; if (CondUndef !== 1'b1) begin bad++; $display("FAIL nv_undef got=%b exp=1", CondUndef); end
        total++; if (PCSrc !== 1'b0) begin bad++; $display("FAIL nv_pcsrc got=%b exp=0", PCSrc); end
        $display("test_signed_reserved: flags=%b", Flags);
    endtask

    task automatic test_stall();
        load_flags(4'b1000);
        drive(1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        total++; if (PCSrc !== 1'b1) begin bad++; $display("FAIL stall_pcsrc got=%b exp=1", PCSrc); end
        tick();
        total++; if (Flags !== 4'b1000) begin bad++; $display("FAIL stall_hold got=%b exp=1000", Flags); end
        drive(1'b1, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (Flags !== 4'b1111) begin bad++; $display("FAIL stall_release got=%b exp=1111", Flags); end
        $display("test_stall: flags=%b", Flags);
    endtask

    task automatic test_reset_midprogram();
        load_flags(4'b1011);
        drive(1'b0, 4'hE, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL midreset_regwrite got=%b exp=0", RegWrite); end
        tick();
        total++; if (Flags !== 4'h0) begin bad++; $display("FAIL midreset_flags got=%h exp=0", Flags); end
        $display("test_reset_midprogram: flags=%h", Flags);
    endtask

    task automatic test_random();
        bit ce, e_pc, e_rw, e_mw, e_und;
        for (int i = 0; i < 200; i++) begin
            drive(($urandom_range(0, 15) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            ce    = cond_pass(Cond, model_flags);
            e_und = (Cond == 4'hF);
            e_pc  = reset && PCS && ce;
            e_mw  = reset && MemW && ce;
            e_rw  = reset && RegW && ce && !NoWrite;
            total++; if (CondEx !== ce) begin bad++; $display("FAIL rnd_condex i=%0d got=%b exp=%b", i, CondEx, ce); end
            total++; if (CondUndef !== e_und) begin bad++; $display("FAIL rnd_undef i=%0d got=%b exp=%b", i, CondUndef, e_und); end
            total++; if (PCSrc !== e_pc) begin bad++; $display("FAIL rnd_pcsrc i=%0d got=%b exp=%b", i, PCSrc, e_pc); end
            total++; if (MemWrite !== e_mw) begin bad++; $display("FAIL rnd_memwrite i=%0d got=%b exp=%b", i, MemWrite, e_mw); end
            total++; if (RegWrite !== e_rw) begin bad++; $display("FAIL rnd_regwrite i=%0d got=%b exp=%b", i, RegWrite, e_rw); end
            tick();
            total++; if (Flags !== model_flags) begin bad++; $display("FAIL rnd_flags i=%0d got=%h exp=%h", i, Flags, model_flags); end
            $display("rnd %0d: rst=%b cond=%h fw=%b alu=%h stall=%b -> flags=%h", i, reset, Cond, FlagW, ALUFlags, Stall, Flags);
        end
    endtask

    initial begin
        reset = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; Stall = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_cmp_beq();
        test_partial();
        test_failed_cond();
        test_signed_reserved();
        test_stall();
        test_reset_midprogram();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
